vx_csr_rmw_arb: RTL

- Sequencer and arbiter in front of the per-core CSR data block's single read port and single write port.
- Accepts CSR operations from NUM_REQS requesters: req 0 = pipeline CSR unit, req 1 = host/debug path.
- Executes each operation as an atomic read-modify-write (RW/RS/RC semantics) and returns the old CSR value.
- Only one operation is in flight at a time, so no two requesters can interleave on the same CSR.

---
 rtl/vx_csr_arb_pkg.sv | 23 ++
 rtl/vx_csr_rr_grant.sv | 34 +++
 rtl/vx_csr_rmw_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vx_csr_arb_pkg.sv
// Shared types and helpers for the CSR read-modify-write arbiter.
package vx_csr_arb_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2,
        CSR_OP_RD = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_RSP   = 2'd3
    } arb_state_e;

    // Takes the two top address bits; 2'b11 marks a read-only CSR.
    function automatic logic csr_is_ro(input logic [1:0] addr_hi);
        return addr_hi == 2'b11;
    endfunction

endpackage

// File: rtl/vx_csr_rr_grant.sv
// One-hot grant among NUM_REQS requesters, searching upward from ptr.
module vx_csr_rr_grant #(
    parameter int NUM_REQS = 2,
    parameter int IDXW     = 1
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [IDXW-1:0]     ptr,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDXW-1:0]     index
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQS) begin
                pos = pos - NUM_REQS;
            end
            if (enable && !found && valid[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = IDXW'(pos);
            end
        end
    end

endmodule

// File: rtl/vx_csr_rmw_arb.sv
// Atomic CSR read-modify-write sequencer shared by NUM_REQS requesters.
// CSR_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin.
module vx_csr_rmw_arb
    import vx_csr_arb_pkg::*;
#(
    parameter int NUM_REQS   = 2,
    parameter int ADDR_BITS  = 12,
    parameter int WID_BITS   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    output logic [NUM_REQS-1:0]            req_ready,
    input  logic [NUM_REQS*2-1:0]          req_op,
    input  logic [NUM_REQS*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQS*WID_BITS-1:0]   req_wid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQS-1:0]            rsp_valid,
    input  logic [NUM_REQS-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           csr_read_enable,
    output logic [ADDR_BITS-1:0]           csr_read_addr,
    output logic [WID_BITS-1:0]            csr_read_wid,
    input  logic [DATA_WIDTH-1:0]          csr_read_data,
    output logic                           csr_write_enable,
    output logic [ADDR_BITS-1:0]           csr_write_addr,
    output logic [WID_BITS-1:0]            csr_write_wid,
    output logic [DATA_WIDTH-1:0]          csr_write_data,
    input  logic                           stall
);

    localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    arb_state_e            state;
    arb_state_e            state_n;
    logic [IDXW-1:0]       ptr;
    logic [IDXW-1:0]       sel;
    logic [IDXW-1:0]       gnt_idx;
    logic [NUM_REQS-1:0]   gnt;
    csr_op_e               op_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WID_BITS-1:0]   wid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  need_write;
    logic                  is_ro;

    vx_csr_rr_grant #(
        .NUM_REQS (NUM_REQS),
        .IDXW     (IDXW)
    ) u_grant (
        .valid  (req_valid),
        .ptr    (ptr),
        .enable ((state == ARB_IDLE) && !stall),
        .grant  (gnt),
        .index  (gnt_idx)
    );

    assign is_ro = csr_is_ro(addr_q[ADDR_BITS-1 -: 2]);

    // A zero set/clear mask leaves the CSR untouched, so it is not a write.
    assign need_write = (op_q == CSR_OP_RW)
                     || (((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC))
                         && (|data_q));

    always_comb begin
        unique case (op_q)
            CSR_OP_RW: new_val = data_q;
            CSR_OP_RS: new_val = old_q | data_q;
            CSR_OP_RC: new_val = old_q & ~data_q;
            default:   new_val = old_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARB_IDLE: begin
                if (|gnt) state_n = ARB_READ;
            end
            ARB_READ: begin
                if (!stall) begin
                    state_n = (need_write && !is_ro) ? ARB_WRITE : ARB_RSP;
                end
            end
            ARB_WRITE: begin
                if (!stall) state_n = ARB_RSP;
            end
            ARB_RSP: begin
                if (rsp_ready[sel]) state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = '0;
        rsp_valid        = '0;
        rsp_err          = 1'b0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        unique case (state)
            ARB_IDLE:  req_ready = gnt;
            ARB_READ:  csr_read_enable = 1'b1;
            ARB_WRITE: csr_write_enable = !stall;
            ARB_RSP: begin
                rsp_valid = NUM_REQS'(1) << sel;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            sel    <= '0;
            op_q   <= CSR_OP_RW;
            addr_q <= '0;
            wid_q  <= '0;
            data_q <= '0;
            old_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state == ARB_IDLE) && (|gnt)) begin
                sel    <= gnt_idx;
                op_q   <= csr_op_e'(req_op[2*int'(gnt_idx) +: 2]);
                addr_q <= req_addr[ADDR_BITS*int'(gnt_idx) +: ADDR_BITS];
                wid_q  <= req_wid[WID_BITS*int'(gnt_idx) +: WID_BITS];
                data_q <= req_data[DATA_WIDTH*int'(gnt_idx) +: DATA_WIDTH];
`ifdef CSR_ARB_FIXED_PRIO_EN
                ptr    <= '0;
`else
                ptr    <= (gnt_idx == IDXW'(NUM_REQS - 1)) ? '0
                                                           : gnt_idx + 1'b1;
`endif
            end
            // Re-captured every READ cycle so a stalled read stays fresh.
            if (state == ARB_READ) begin
                old_q <= csr_read_data;
                err_q <= need_write && is_ro;
            end
        end
    end

    assign rsp_data       = old_q;
    assign csr_read_addr  = addr_q;
    assign csr_read_wid   = wid_q;
    assign csr_write_addr = addr_q;
    assign csr_write_wid  = wid_q;
    assign csr_write_data = new_val;

endmodule
